// File: rtl/dds_freq_ramp_ctrl.sv
// dds_freq_ramp_ctrl: frequency-ramp sequencer for one DDS channel.
// Steps freq_add linearly from 0 to (target - freq), then folds the offset into freq.
// Optional macro DDS_RAMP_PHASE_SYNC_EN adds a SYNC state that holds the ramp start
// until the DDS phase accumulator wraps.
module dds_freq_ramp_ctrl #(
  parameter int unsigned DIV_W        = 16,
  parameter logic [31:0] DEFAULT_FREQ = 32'h0147AEB8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_target,
  input  logic [31:0]      cmd_step,
  input  logic [DIV_W-1:0] cmd_div,
  input  logic             abort,
  input  logic [31:0]      dds_phase,
  output logic [31:0]      freq,
  output logic [31:0]      freq_add,
  output logic             busy,
  output logic             done
);

  localparam int unsigned FW = 32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SYNC   = 3'd2,
    S_RAMP   = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [FW-1:0]    freq_q, freq_d;
  logic [FW-1:0]    add_q, add_d;
  logic [FW-1:0]    tgt_q, tgt_d;
  logic [FW-1:0]    step_q, step_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [FW-1:0]    delta_q, delta_d;
  logic             dir_q, dir_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [FW-1:0]    delta_load;
  logic [FW-1:0]    remaining;
  logic [FW-1:0]    rem_abs;
  logic             last_step;
  logic             phase_wrap;

`ifdef DDS_RAMP_PHASE_SYNC_EN
  logic phase_msb_q;

  // Remember previous phase MSB to detect the 1->0 wrap of the accumulator
  always_ff @(posedge clk or posedge reset) begin
    if (reset) phase_msb_q <= 1'b0;
    else       phase_msb_q <= dds_phase[31];
  end

  assign phase_wrap = phase_msb_q & ~dds_phase[31];
`else
  logic unused_phase;
  assign unused_phase = ^dds_phase;
  assign phase_wrap   = 1'b0;
`endif

  // Shortest signed path to target and distance still to travel
  assign delta_load = tgt_q - freq_q;
  assign remaining  = delta_q - add_q;
  assign rem_abs    = dir_q ? FW'(-remaining) : remaining;
  assign last_step  = (rem_abs <= step_q);

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      freq_q  <= DEFAULT_FREQ;
      add_q   <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      delta_q <= '0;
      dir_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      freq_q  <= freq_d;
      add_q   <= add_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      delta_q <= delta_d;
      dir_q   <= dir_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic; outputs are derived from the next state
  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    add_d   = add_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    delta_d = delta_q;
    dir_d   = dir_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          tgt_d   = cmd_target;
          step_d  = cmd_step;
          div_d   = cmd_div;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          freq_d  = freq_q + add_q;
          add_d   = '0;
          state_d = S_IDLE;
        end else begin
          delta_d = delta_load;
          dir_d   = delta_load[FW-1];
          cnt_d   = div_q;
          if (delta_load == '0 || step_q == '0) begin
            state_d = S_COMMIT;
          end else begin
`ifdef DDS_RAMP_PHASE_SYNC_EN
            state_d = S_SYNC;
`else
            state_d = S_RAMP;
`endif
          end
        end
      end
      S_SYNC: begin
        if (abort) begin
          freq_d  = freq_q + add_q;
          add_d   = '0;
          state_d = S_IDLE;
        end else if (phase_wrap) begin
          cnt_d   = div_q;
          state_d = S_RAMP;
        end
      end
      S_RAMP: begin
        if (abort) begin
          freq_d  = freq_q + add_q;
          add_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else begin
          cnt_d = div_q;
          if (last_step) begin
            add_d   = delta_q;
            state_d = S_COMMIT;
          end else if (dir_q) begin
            add_d = add_q - step_q;
          end else begin
            add_d = add_q + step_q;
          end
        end
      end
      S_COMMIT: begin
        freq_d  = freq_q + add_q;
        add_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_COMMIT);
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign freq      = freq_q;
  assign freq_add  = add_q;

endmodule

// File: tb/tb_dds_freq_ramp_ctrl.sv
// Directed self-checking bench for dds_freq_ramp_ctrl (default build, no phase sync).
module tb_dds_freq_ramp_ctrl;

  localparam int unsigned DIV_W = 16;
  localparam logic [31:0] DEF   = 32'h0147AEB8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [31:0]      cmd_target = '0;
  logic [31:0]      cmd_step = '0;
  logic [DIV_W-1:0] cmd_div = '0;
  logic             abort = 1'b0;
  logic [31:0]      dds_phase = '0;
  logic [31:0]      freq;
  logic [31:0]      freq_add;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_err    = 0;

  dds_freq_ramp_ctrl #(.DIV_W(DIV_W), .DEFAULT_FREQ(DEF)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_target(cmd_target), .cmd_step(cmd_step), .cmd_div(cmd_div), .abort(abort),
    .dds_phase(dds_phase), .freq(freq), .freq_add(freq_add), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Free-running phase stimulus; must not influence the default build
  always @(posedge clk) dds_phase <= dds_phase + 32'h0B000000;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    abort = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // Present a command for one accepting edge; returns with DUT in LOAD
  task automatic send(input logic [31:0] tgt, input logic [31:0] stp, input logic [DIV_W-1:0] dv);
    cmd_target = tgt;
    cmd_step   = stp;
    cmd_div    = dv;
    cmd_valid  = 1'b1;
    cyc();
    cmd_valid  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (freq !== DEF) begin n_err++; $display("FAIL reset_freq: got %h expected %h", freq, DEF); end
    n_checks++; if (freq_add !== 32'h0) begin n_err++; $display("FAIL reset_add: got %h expected 0", freq_add); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
    // Asynchronous reset in the middle of a ramp
    send(32'h028F5C71, 32'h00100000, 16'd0);
    cyc();
    cyc();
    cyc();
    n_checks++; if (freq_add !== 32'h00200000) begin n_err++; $display("FAIL midramp_add: got %h expected 00200000", freq_add); end
    #3 reset = 1'b1;
    #1;
    n_checks++; if (freq !== DEF || freq_add !== 32'h0) begin n_err++; $display("FAIL async_reset_freq: got %h/%h expected %h/0", freq, freq_add, DEF); end
    n_checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL async_reset_ctl: got ready=%b busy=%b expected 1/0", cmd_ready, busy); end
    cyc();
    reset = 1'b0;
    cyc();
    n_checks++; if (freq !== DEF || freq_add !== 32'h0 || busy !== 1'b0) begin n_err++; $display("FAIL post_reset: got %h/%h busy=%b", freq, freq_add, busy); end
  endtask

  task automatic test_up_ramp();
    logic [31:0] tgt, stp, dlt, exp_add, k_step, eff, prev_eff;
    do_reset();
    tgt = 32'h028F5C71;
    stp = 32'h00100000;
    dlt = tgt - DEF;
    exp_add = '0;
    prev_eff = DEF;
    send(tgt, stp, 16'd3);
    n_checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin n_err++; $display("FAIL up_load_ctl: got busy=%b ready=%b expected 1/0", busy, cmd_ready); end
    cyc();
    n_checks++; if (freq_add !== 32'h0) begin n_err++; $display("FAIL up_ramp_entry: got %h expected 0", freq_add); end
    for (int k = 1; k <= 21; k++) begin
      for (int c = 0; c < 4; c++) begin
        cyc();
        if (c == 3) begin
          k_step  = 32'(k) * stp;
          exp_add = (k_step >= dlt) ? dlt : k_step;
        end
        eff = freq + freq_add;
        n_checks++; if (freq_add !== exp_add) begin n_err++; $display("FAIL up_add step%0d c%0d: got %h expected %h", k, c, freq_add, exp_add); end
        n_checks++; if (eff > tgt || eff < prev_eff) begin n_err++; $display("FAIL up_monotonic step%0d: got %h prev %h limit %h", k, eff, prev_eff, tgt); end
        prev_eff = eff;
        if (!(k == 21 && c == 3)) begin
          n_checks++; if (done !== 1'b0) begin n_err++; $display("FAIL up_early_done step%0d: got %b expected 0", k, done); end
        end
      end
    end
    n_checks++; if (done !== 1'b1 || freq_add !== 32'h0147ADB9) begin n_err++; $display("FAIL up_clamp_done: got done=%b add=%h expected 1/0147adb9", done, freq_add); end
    cyc();
    n_checks++; if (freq !== tgt || freq_add !== 32'h0) begin n_err++; $display("FAIL up_commit: got %h/%h expected %h/0", freq, freq_add, tgt); end
    n_checks++; if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL up_idle: got done=%b busy=%b ready=%b", done, busy, cmd_ready); end
  endtask

  task automatic test_down_ramp();
    logic [31:0] tgt, stp, mag, k_step, exp_add, eff, prev_eff;
    do_reset();
    tgt = 32'h00A3D75C;
    stp = 32'h00100000;
    mag = DEF - tgt;
    prev_eff = DEF;
    send(tgt, stp, 16'd0);
    cyc();
    for (int k = 1; k <= 11; k++) begin
      cyc();
      k_step  = 32'(k) * stp;
      exp_add = (k_step >= mag) ? -mag : -k_step;
      eff = freq + freq_add;
      n_checks++; if (freq_add !== exp_add) begin n_err++; $display("FAIL down_add step%0d: got %h expected %h", k, freq_add, exp_add); end
      n_checks++; if (eff > prev_eff || eff < tgt) begin n_err++; $display("FAIL down_monotonic step%0d: got %h prev %h", k, eff, prev_eff); end
      prev_eff = eff;
    end
    n_checks++; if (done !== 1'b1) begin n_err++; $display("FAIL down_done: got %b expected 1", done); end
    cyc();
    n_checks++; if (freq !== 32'h00A3D75C || freq_add !== 32'h0) begin n_err++; $display("FAIL down_commit: got %h/%h expected 00a3d75c/0", freq, freq_add); end
  endtask

  task automatic test_abort();
    do_reset();
    send(32'h028F5C71, 32'h00100000, 16'd3);
    cyc();
    repeat (20) cyc();
    n_checks++; if (freq_add !== 32'h00500000) begin n_err++; $display("FAIL abort_pre: got %h expected 00500000", freq_add); end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    n_checks++; if (freq !== 32'h0197AEB8 || freq_add !== 32'h0) begin n_err++; $display("FAIL abort_fold: got %h/%h expected 0197aeb8/0", freq, freq_add); end
    n_checks++; if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL abort_idle: got done=%b busy=%b ready=%b", done, busy, cmd_ready); end
    cyc();
    n_checks++; if (done !== 1'b0 || freq !== 32'h0197AEB8) begin n_err++; $display("FAIL abort_after: got done=%b freq=%h", done, freq); end
    // Abort on the same edge as the second step: the step is dropped
    do_reset();
    send(32'h028F5C71, 32'h00100000, 16'd3);
    cyc();
    repeat (7) cyc();
    n_checks++; if (freq_add !== 32'h00100000) begin n_err++; $display("FAIL abort_coinc_pre: got %h expected 00100000", freq_add); end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    n_checks++; if (freq !== DEF + 32'h00100000 || freq_add !== 32'h0 || done !== 1'b0) begin n_err++; $display("FAIL abort_coinc: got %h/%h done=%b expected %h/0/0", freq, freq_add, done, DEF + 32'h00100000); end
  endtask

  task automatic test_degenerate();
    do_reset();
    send(DEF, 32'h00100000, 16'd3);
    n_checks++; if (done !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL same_load: got done=%b busy=%b expected 0/1", done, busy); end
    cyc();
    n_checks++; if (done !== 1'b1 || freq_add !== 32'h0) begin n_err++; $display("FAIL same_done: got done=%b add=%h expected 1/0", done, freq_add); end
    cyc();
    n_checks++; if (freq !== DEF || done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL same_end: got %h done=%b busy=%b", freq, done, busy); end
    send(32'h02000000, 32'h0, 16'd2);
    cyc();
    n_checks++; if (done !== 1'b1 || freq_add !== 32'h0) begin n_err++; $display("FAIL zero_step_done: got done=%b add=%h expected 1/0", done, freq_add); end
    cyc();
    n_checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL zero_step_idle: got busy=%b ready=%b", busy, cmd_ready); end
    // cmd_valid held with a different target while busy must not be taken
    do_reset();
    cmd_target = 32'h0157AEB8;
    cmd_step   = 32'h00080000;
    cmd_div    = 16'd1;
    cmd_valid  = 1'b1;
    cyc();
    cmd_target = 32'h0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_checks++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL held_ready c%0d: got %b expected 0", i, cmd_ready); end
    end
    cmd_valid = 1'b0;
    cyc();
    cyc();
    n_checks++; if (freq !== 32'h0157AEB8 || busy !== 1'b0) begin n_err++; $display("FAIL held_result: got %h busy=%b expected 0157aeb8/0", freq, busy); end
  endtask

  task automatic test_wrap();
    do_reset();
    send(32'hFFF00000, 32'h01000000, 16'd0);
    cyc();
    cyc();
    n_checks++; if (freq_add !== 32'hFF000000) begin n_err++; $display("FAIL wrap_step1: got %h expected ff000000", freq_add); end
    cyc();
    n_checks++; if (freq_add !== 32'hFFF00000 - DEF || done !== 1'b1) begin n_err++; $display("FAIL wrap_clamp: got %h done=%b expected %h/1", freq_add, done, 32'hFFF00000 - DEF); end
    cyc();
    n_checks++; if (freq !== 32'hFFF00000 || freq_add !== 32'h0) begin n_err++; $display("FAIL wrap_commit: got %h/%h expected fff00000/0", freq, freq_add); end
  endtask

  task automatic test_start_latency();
    do_reset();
    send(32'h02000000, 32'h00010000, 16'd5);
    cyc();
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (freq_add !== 32'h0) begin n_err++; $display("FAIL latency_early c%0d: got %h expected 0", i, freq_add); end
      cyc();
    end
    n_checks++; if (freq_add !== 32'h00010000) begin n_err++; $display("FAIL latency_first: got %h expected 00010000", freq_add); end
  endtask

  initial begin
    test_reset();
    test_up_ramp();
    test_down_ramp();
    test_abort();
    test_degenerate();
    test_wrap();
    test_start_latency();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
